// File: rtl/mem_data_access.sv
// MEM-stage data-access controller: one dbus transaction per load/store, stalls until done.
// Optional MEM_DIFF_SKIP_EN flags completed accesses outside the main RAM window.
module mem_data_access #(
    parameter int                ADDR_W   = 64,
    parameter int                DATA_W   = 64,
    parameter logic [ADDR_W-1:0] RAM_BASE = 64'h8000_0000,
    parameter logic [ADDR_W-1:0] RAM_SIZE = 64'h0800_0000
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_size,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              excep_flush,
    output logic              dbus_req_valid,
    input  logic              dbus_req_ready,
    output logic              dbus_req_we,
    output logic [ADDR_W-1:0] dbus_req_addr,
    output logic [DATA_W-1:0] dbus_req_wdata,
    output logic [7:0]        dbus_req_wstrb,
    input  logic              dbus_resp_valid,
    input  logic [DATA_W-1:0] dbus_resp_data,
    output logic [DATA_W-1:0] mem_dm,
    output logic [7:0]        mem_dre,
    output logic              mem_misalign,
    output logic              data_read_stall,
    output logic              mem2diff_skip
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic              r_abort;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_mask;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_wstrb;
    logic [DATA_W-1:0] r_rdata;

    logic [7:0]        w_mask;
    logic [2:0]        w_amask;
    logic              w_misalign;
    logic              w_go;
    logic              w_done;
    logic              w_resp;

    // lane mask and low-address bits that must be zero for natural alignment
    always_comb begin
        w_mask  = 8'h01;
        w_amask = 3'b000;
        unique case (mem_size)
            2'd0: begin w_mask = 8'h01; w_amask = 3'b000; end
            2'd1: begin w_mask = 8'h03; w_amask = 3'b001; end
            2'd2: begin w_mask = 8'h0F; w_amask = 3'b011; end
            2'd3: begin w_mask = 8'hFF; w_amask = 3'b111; end
        endcase
    end

    assign w_misalign = (mem_addr[2:0] & w_amask) != 3'b000;
    assign w_go       = mem_req & ~w_misalign & ~excep_flush;
    assign w_done     = r_state == S_DONE;
    assign w_resp     = (r_state == S_WAIT) & dbus_resp_valid;

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) r_state <= S_IDLE;
        else         r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: if (w_go) w_state_nx = S_REQ;
            S_REQ:  if (dbus_req_ready) w_state_nx = S_WAIT;
            S_WAIT: if (dbus_resp_valid)
                        w_state_nx = (r_abort | excep_flush) ? S_IDLE : S_DONE;
            S_DONE: w_state_nx = S_IDLE;
        endcase
    end

    // a flush mid-transaction lets the bus finish but drops the result
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst)
            r_abort <= 1'b0;
        else if (w_resp)
            r_abort <= 1'b0;
        else if (excep_flush && (r_state == S_REQ || r_state == S_WAIT))
            r_abort <= 1'b1;
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_mask  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == S_IDLE && w_go) begin
                r_we    <= mem_we;
                r_addr  <= mem_addr;
                r_mask  <= w_mask;
                r_wdata <= mem_we ? (mem_wdata << {mem_addr[2:0], 3'b000}) : '0;
                r_wstrb <= mem_we ? (w_mask << mem_addr[2:0]) : 8'h00;
            end
            if (w_resp)
                r_rdata <= r_we ? '0 : (dbus_resp_data >> {r_addr[2:0], 3'b000});
        end
    end

    assign dbus_req_valid  = r_state == S_REQ;
    assign dbus_req_we     = r_we;
    assign dbus_req_addr   = {r_addr[ADDR_W-1:3], 3'b000};
    assign dbus_req_wdata  = r_wdata;
    assign dbus_req_wstrb  = r_wstrb;

    assign mem_dm          = w_done ? r_rdata : '0;
    assign mem_dre         = (w_done & ~r_we) ? r_mask : 8'h00;
    assign mem_misalign    = ~cpu_rst & mem_req & w_misalign;
    assign data_read_stall = ~cpu_rst & mem_req & ~w_misalign & ~w_done;

`ifdef MEM_DIFF_SKIP_EN
    assign mem2diff_skip = w_done &
        ((r_addr < RAM_BASE) || (r_addr >= RAM_BASE + RAM_SIZE));
`else
    assign mem2diff_skip = 1'b0;
`endif

endmodule

// File: tb/tb_mem_data_access.sv
// Bench for mem_data_access: transaction-level model, bus responder, directed vectors.
// Honours MEM_DIFF_SKIP_EN the same way the design does.
module tb_mem_data_access;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] SIZE = 64'h0800_0000;

    logic        clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [63:0] mem_addr = '0;
    logic [1:0]  mem_size = '0;
    logic [63:0] mem_wdata = '0;
    logic        excep_flush = 1'b0;
    logic        dbus_req_valid;
    logic        dbus_req_ready = 1'b0;
    logic        dbus_req_we;
    logic [63:0] dbus_req_addr;
    logic [63:0] dbus_req_wdata;
    logic [7:0]  dbus_req_wstrb;
    logic        dbus_resp_valid = 1'b0;
    logic [63:0] dbus_resp_data = '0;
    logic [63:0] mem_dm;
    logic [7:0]  mem_dre;
    logic        mem_misalign;
    logic        data_read_stall;
    logic        mem2diff_skip;

    int n_vec = 0;
    int n_err = 0;

    mem_data_access dut (
        .cpu_clk_50M    (clk),
        .cpu_rst        (cpu_rst),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_size       (mem_size),
        .mem_wdata      (mem_wdata),
        .excep_flush    (excep_flush),
        .dbus_req_valid (dbus_req_valid),
        .dbus_req_ready (dbus_req_ready),
        .dbus_req_we    (dbus_req_we),
        .dbus_req_addr  (dbus_req_addr),
        .dbus_req_wdata (dbus_req_wdata),
        .dbus_req_wstrb (dbus_req_wstrb),
        .dbus_resp_valid(dbus_resp_valid),
        .dbus_resp_data (dbus_resp_data),
        .mem_dm         (mem_dm),
        .mem_dre        (mem_dre),
        .mem_misalign   (mem_misalign),
        .data_read_stall(data_read_stall),
        .mem2diff_skip  (mem2diff_skip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit misal(input logic req, input logic [63:0] a, input logic [1:0] s);
        return req && ((a % (64'd1 << s)) != 0);
    endfunction

    function automatic logic [7:0] lanes(input logic [1:0] s, input logic [63:0] a);
        int nb;
        int m;
        nb = 1 << s;
        m  = ((1 << nb) - 1) << (a % 8);
        return 8'(m & 255);
    endfunction

    // bus responder: ready after rdy_lat cycles of valid, response resp_lat cycles after handshake
    int          rdy_lat = 0;
    int          resp_lat = 0;
    logic [63:0] resp_word = '0;
    int          hs_n = 0;
    logic [63:0] hs_addr = '0;
    logic [63:0] hs_wdata = '0;
    logic [7:0]  hs_wstrb = '0;

    initial begin : agent
        int  rcnt;
        int  pcnt;
        bit  pend;
        rcnt = 0;
        pcnt = 0;
        pend = 0;
        forever begin
            @(posedge clk);
            #2;
            if (cpu_rst) begin
                dbus_req_ready  = 1'b0;
                dbus_resp_valid = 1'b0;
                pend = 0;
                rcnt = 0;
            end else begin
                dbus_resp_valid = 1'b0;
                if (dbus_req_ready) begin
                    pend = 1;
                    pcnt = resp_lat;
                end
                dbus_req_ready = 1'b0;
                if (pend) begin
                    if (pcnt == 0) begin
                        dbus_resp_valid = 1'b1;
                        dbus_resp_data  = resp_word;
                        pend = 0;
                    end else begin
                        pcnt--;
                    end
                end
                if (dbus_req_valid) begin
                    if (rcnt >= rdy_lat) begin
                        dbus_req_ready = 1'b1;
                        rcnt = 0;
                        hs_n++;
                        hs_addr  = dbus_req_addr;
                        hs_wdata = dbus_req_wdata;
                        hs_wstrb = dbus_req_wstrb;
                    end else begin
                        rcnt++;
                    end
                end
            end
        end
    end

    // transaction model: one access in flight, request phase, response phase, one result cycle
    logic        m_busy, m_hs, m_abort, m_done, m_we;
    logic [63:0] m_addr, m_wd, m_rd;
    logic [1:0]  m_size;

    always @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            m_busy <= 0; m_hs <= 0; m_abort <= 0; m_done <= 0;
            m_we <= 0; m_addr <= '0; m_wd <= '0; m_rd <= '0; m_size <= '0;
        end else if (m_done) begin
            m_done <= 0;
        end else if (!m_busy) begin
            if (!misal(mem_req, mem_addr, mem_size) && mem_req && !excep_flush) begin
                m_busy <= 1; m_hs <= 0; m_abort <= 0;
                m_we <= mem_we; m_addr <= mem_addr;
                m_wd <= mem_wdata; m_size <= mem_size;
            end
        end else if (!m_hs) begin
            if (dbus_req_ready) m_hs <= 1;
            if (excep_flush) m_abort <= 1;
        end else if (dbus_resp_valid) begin
            m_busy <= 0;
            m_abort <= 0;
            if (!m_abort && !excep_flush) begin
                m_done <= 1;
                m_rd <= m_we ? 64'd0 : dbus_resp_data >> (8 * (m_addr % 8));
            end
        end else if (excep_flush) begin
            m_abort <= 1;
        end
    end

    always @(negedge clk) begin : compare
        bit exp_skip;
        chk("misalign", 64'(mem_misalign),
            64'(!cpu_rst && misal(mem_req, mem_addr, mem_size)));
        chk("stall", 64'(data_read_stall),
            64'(!cpu_rst && mem_req && !misal(mem_req, mem_addr, mem_size) && !m_done));
        if (m_busy && !m_hs) begin
            chk("req_valid", 64'(dbus_req_valid), 64'd1);
            chk("req_we", 64'(dbus_req_we), 64'(m_we));
            chk("req_addr", dbus_req_addr, m_addr - (m_addr % 8));
            chk("req_wdata", dbus_req_wdata, m_we ? m_wd << (8 * (m_addr % 8)) : 64'd0);
            chk("req_wstrb", 64'(dbus_req_wstrb), m_we ? 64'(lanes(m_size, m_addr)) : 64'd0);
        end else begin
            chk("req_valid", 64'(dbus_req_valid), 64'd0);
        end
        chk("mem_dm", mem_dm, m_done ? m_rd : 64'd0);
        chk("mem_dre", 64'(mem_dre), (m_done && !m_we) ? 64'(lanes(m_size, 64'd0)) : 64'd0);
`ifdef MEM_DIFF_SKIP_EN
        exp_skip = m_done && (m_addr < BASE || m_addr >= BASE + SIZE);
`else
        exp_skip = 0;
`endif
        chk("skip", 64'(mem2diff_skip), 64'(exp_skip));
    end

    task automatic start(input logic we, input logic [63:0] a, input logic [1:0] s,
                         input logic [63:0] wd, input logic [63:0] rw,
                         input int rl, input int pl);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = a;
        mem_size  = s;
        mem_wdata = wd;
        resp_word = rw;
        rdy_lat   = rl;
        resp_lat  = pl;
    endtask

    // ends at +3 of the first cycle with stall low (DONE, or a misaligned cycle)
    task automatic wait_done(output int n);
        n = 0;
        #1;
        while (data_read_stall && n < 60) begin
            n++;
            @(posedge clk);
            #3;
        end
        if (n >= 60) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: stall still high after %0d cycles", n);
        end
    endtask

    task automatic release_req();
        @(posedge clk);
        #2;
        mem_req = 1'b0;
        excep_flush = 1'b0;
    endtask

    initial begin : stim
        int n;
        int h0;
        mem_req  = 1'b1;
        mem_addr = 64'h8000_0001;
        mem_size = 2'd3;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_stall", 64'(data_read_stall), 64'd0);
        chk("rst_misalign", 64'(mem_misalign), 64'd0);
        chk("rst_valid", 64'(dbus_req_valid), 64'd0);
        @(posedge clk);
        #2;
        cpu_rst = 1'b0;
        mem_req = 1'b0;
        @(posedge clk);

        // T1 aligned doubleword load
        #2;
        start(0, 64'h8000_0010, 2'd3, 64'd0, 64'h1122_3344_5566_7788, 0, 0);
        wait_done(n);
        chk("t1_stall_cycles", 64'(n), 64'd3);
        chk("t1_dm", mem_dm, 64'h1122_3344_5566_7788);
        chk("t1_dre", 64'(mem_dre), 64'hFF);
        chk("t1_skip", 64'(mem2diff_skip), 64'd0);
        release_req();

        // T2 byte store lane 5, halfword load lane 6
        start(1, 64'h8000_0005, 2'd0, 64'hAB, 64'h5A5A_5A5A_5A5A_5A5A, 0, 0);
        wait_done(n);
        chk("t2_sb_wstrb", 64'(hs_wstrb), 64'h20);
        chk("t2_sb_wdata", hs_wdata, 64'h0000_AB00_0000_0000);
        chk("t2_sb_addr", hs_addr, 64'h8000_0000);
        chk("t2_sb_dm", mem_dm, 64'd0);
        chk("t2_sb_dre", 64'(mem_dre), 64'd0);
        release_req();
        start(0, 64'h8000_0006, 2'd1, 64'd0, 64'hBEEF_0000_0000_0000, 0, 0);
        wait_done(n);
        chk("t2_lh_dm", mem_dm, 64'hBEEF);
        chk("t2_lh_dre", 64'(mem_dre), 64'h03);
        release_req();

        // word store upper half, byte load lane 3
        start(1, 64'h8000_0104, 2'd2, 64'hDEAD_BEEF, 64'h1, 0, 1);
        wait_done(n);
        chk("sw_wstrb", 64'(hs_wstrb), 64'hF0);
        chk("sw_wdata", hs_wdata, 64'hDEAD_BEEF_0000_0000);
        chk("sw_stall_cycles", 64'(n), 64'd4);
        release_req();
        start(0, 64'h8000_0003, 2'd0, 64'd0, 64'h0000_0000_CC00_0000, 0, 0);
        wait_done(n);
        chk("lb_dm", mem_dm, 64'hCC);
        chk("lb_dre", 64'(mem_dre), 64'h01);
        release_req();

        // T3 ready held low 5 cycles
        h0 = hs_n;
        start(0, 64'h8000_0018, 2'd3, 64'd0, 64'h0123_4567_89AB_CDEF, 5, 0);
        wait_done(n);
        chk("t3_stall_cycles", 64'(n), 64'd8);
        chk("t3_handshakes", 64'(hs_n - h0), 64'd1);
        chk("t3_dm", mem_dm, 64'h0123_4567_89AB_CDEF);
        release_req();

        // T4 flush in WAIT, new request follows the abort response
        h0 = hs_n;
        start(0, 64'h8000_0020, 2'd3, 64'd0, 64'h5555, 0, 3);
        repeat (2) @(posedge clk);
        #2;
        excep_flush = 1'b1;
        mem_req = 1'b0;
        @(posedge clk);
        #2;
        excep_flush = 1'b0;
        start(0, 64'h8000_0044, 2'd2, 64'd0, 64'h9988_7766_0000_0000, 0, 0);
        wait_done(n);
        chk("t4_stall_cycles", 64'(n), 64'd6);
        chk("t4_handshakes", 64'(hs_n - h0), 64'd2);
        chk("t4_addr", hs_addr, 64'h8000_0040);
        chk("t4_dm", mem_dm, 64'h9988_7766);
        chk("t4_dre", 64'(mem_dre), 64'h0F);
        release_req();

        // T5 misaligned word load
        h0 = hs_n;
        start(0, 64'h8000_0002, 2'd2, 64'd0, 64'd0, 0, 0);
        wait_done(n);
        chk("t5_misalign", 64'(mem_misalign), 64'd1);
        chk("t5_stall_cycles", 64'(n), 64'd0);
        release_req();
        repeat (3) @(posedge clk);
        chk("t5_no_request", 64'(hs_n - h0), 64'd0);

        // T6 MMIO load, then reset in WAIT
        #2;
        start(0, 64'h0200_BFF8, 2'd3, 64'd0, 64'h0000_0000_0000_1234, 0, 0);
        wait_done(n);
        chk("t6_dm", mem_dm, 64'h1234);
`ifdef MEM_DIFF_SKIP_EN
        chk("t6_skip", 64'(mem2diff_skip), 64'd1);
`else
        chk("t6_skip", 64'(mem2diff_skip), 64'd0);
`endif
        release_req();
        start(0, 64'h8000_0030, 2'd3, 64'd0, 64'hFFFF, 0, 5);
        repeat (2) @(posedge clk);
        #2;
        cpu_rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(dbus_req_valid), 64'd0);
        chk("t6_rst_stall", 64'(data_read_stall), 64'd0);
        chk("t6_rst_dm", mem_dm, 64'd0);
        repeat (2) @(posedge clk);
        #2;
        cpu_rst = 1'b0;
        mem_req = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        start(0, 64'h8000_0000, 2'd3, 64'd0, 64'hCAFE_F00D_0000_0001, 0, 0);
        wait_done(n);
        chk("t6_post_stall", 64'(n), 64'd3);
        chk("t6_post_dm", mem_dm, 64'hCAFE_F00D_0000_0001);
        chk("t6_post_skip", 64'(mem2diff_skip), 64'd0);
        release_req();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
